// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundle of the hazard-controller signals exchanged with the pipeline.
//   master : pipeline side; drives the IF/ID and ID/EX instructions, the branch
//            resolution and the MDU done pulse, and receives the stall/flush controls.
//   slave  : hazard controller side.
//   Signals: id_instr, ex_instr, ex_br_taken, mdu_done          (pipeline -> ctrl)
//            stall_pc, stall_ifid, stall_idex, bubble_idex,
//            flush_ifid, mdu_start, mdu_err, stall_cnt          (ctrl -> pipeline)
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [31:0]      id_instr;
   logic [31:0]      ex_instr;
   logic             ex_br_taken;
   logic             mdu_done;
   logic             stall_pc;
   logic             stall_ifid;
   logic             stall_idex;
   logic             bubble_idex;
   logic             flush_ifid;
   logic             mdu_start;
   logic             mdu_err;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_instr, ex_instr, ex_br_taken, mdu_done,
      input  stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid,
             mdu_start, mdu_err, stall_cnt
   );

   modport slave (
      input  id_instr, ex_instr, ex_br_taken, mdu_done,
      output stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid,
             mdu_start, mdu_err, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard controller for a 5-stage RV32 pipeline: load-use interlock, taken
//   branch flush, and multi-cycle MDU sequencing with a timeout watchdog.
//   Ports:
//     clk  - pipeline clock, all state on the rising edge
//     rst  - synchronous active-high reset
//     hz   - pipe_hazard_ctrl_if.slave (instructions, branch, MDU handshake,
//            stall/flush controls, sticky MDU error, saturating stall counter)
//   Parameters:
//     MDU_TIMEOUT - MDU_BUSY cycles allowed before a forced abort
//     CNT_W       - stall counter width (must match the interface CNT_W)
module pipe_hazard_ctrl #(
   parameter int unsigned MDU_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input logic              clk,
   input logic              rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam logic [1:0] RUN       = 2'd0;
   localparam logic [1:0] MDU_BUSY  = 2'd1;
   localparam logic [1:0] MDU_DRAIN = 2'd2;

   localparam int unsigned BW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [BW-1:0] BUSY_LAST = BW'(MDU_TIMEOUT - 1);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   logic [1:0]       state_q, state_nx;
   logic [BW-1:0]    busy_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   logic [6:0] ex_opc, id_opc;
   logic [4:0] ex_rd, id_rs1, id_rs2;
   logic       rs1_used, rs2_used, ld_use, mdu_op, busy_timeout;

   logic stall_pc_c, stall_ifid_c, stall_idex_c, bubble_c, flush_c, start_c;

   // Instruction fields not consulted by the hazard logic.
   logic unused_bits;
   assign unused_bits = ^{hz.id_instr[31:25], hz.id_instr[14:7], hz.ex_instr[24:12]};

   // ---------------- decode ----------------
   always_comb begin
      ex_opc   = hz.ex_instr[6:0];
      ex_rd    = hz.ex_instr[11:7];
      id_opc   = hz.id_instr[6:0];
      id_rs1   = hz.id_instr[19:15];
      id_rs2   = hz.id_instr[24:20];
      rs1_used = (id_opc != OP_LUI) && (id_opc != OP_AUIPC) && (id_opc != OP_JAL);
      rs2_used = (id_opc == OP_REG) || (id_opc == OP_STORE) || (id_opc == OP_BR);
      ld_use   = (ex_opc == OP_LOAD) && (ex_rd != 5'd0) &&
                 ((rs1_used && (id_rs1 == ex_rd)) || (rs2_used && (id_rs2 == ex_rd)));
      mdu_op   = (ex_opc == OP_REG) && (hz.ex_instr[31:25] == 7'b0000001);
   end

   assign busy_timeout = (state_q == MDU_BUSY) && !hz.mdu_done && (busy_q == BUSY_LAST);

   // ---------------- control outputs ----------------
   // Branch beats load-use beats MDU start in RUN; reset forces everything low.
   always_comb begin
      stall_pc_c   = 1'b0;
      stall_ifid_c = 1'b0;
      stall_idex_c = 1'b0;
      bubble_c     = 1'b0;
      flush_c      = 1'b0;
      start_c      = 1'b0;
      if (!rst) begin
         case (state_q)
            RUN: begin
               if (hz.ex_br_taken) begin
                  flush_c  = 1'b1;
                  bubble_c = 1'b1;
               end else if (ld_use) begin
                  stall_pc_c   = 1'b1;
                  stall_ifid_c = 1'b1;
                  bubble_c     = 1'b1;
               end else if (mdu_op) begin
                  start_c = 1'b1;
               end
            end
            MDU_BUSY: begin
               stall_pc_c   = 1'b1;
               stall_ifid_c = 1'b1;
               stall_idex_c = 1'b1;
            end
            // The MDU op is replaced by a bubble so it is not started again.
            MDU_DRAIN: bubble_c = 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nx = state_q;
      case (state_q)
         RUN:       if (!hz.ex_br_taken && mdu_op) state_nx = MDU_BUSY;
         MDU_BUSY:  if (hz.mdu_done || busy_timeout) state_nx = MDU_DRAIN;
         MDU_DRAIN: state_nx = RUN;
         default:   state_nx = RUN;
      endcase
   end

   // ---------------- state ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         busy_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_nx;
         // Held at zero outside MDU_BUSY so each entry starts counting from 0.
         if (state_q == MDU_BUSY) busy_q <= busy_q + 1'b1;
         else                     busy_q <= '0;
         if (busy_timeout) err_q <= 1'b1;
         if (stall_pc_c && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hz.stall_pc    = stall_pc_c;
   assign hz.stall_ifid  = stall_ifid_c;
   assign hz.stall_idex  = stall_idex_c;
   assign hz.bubble_idex = bubble_c;
   assign hz.flush_ifid  = flush_c;
   assign hz.mdu_start   = start_c;
   assign hz.mdu_err     = err_q;
   assign hz.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
   localparam int TO = 64;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] LW5 = 32'h0000_A283;
   localparam logic [31:0] ADD = 32'h0072_8333;
   localparam logic [31:0] MUL = 32'h0220_81B3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(16)) hz();
   pipe_hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(hz.slave));

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: an MDU op in flight, how many waiting cycles it has used,
   // whether a drain bubble is owed, the sticky error and the stall total.
   bit m_pending, m_drain, m_err;
   int m_age, m_cnt;

   function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
      logic [6:0] op;
      bit r1, r2;
      op = i[6:0];
      r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
      r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
      return (r1 && i[19:15] == r) || (r2 && i[24:20] == r);
   endfunction

   function automatic bit load_hazard(input logic [31:0] ex, input logic [31:0] id);
      return ex[6:0] == 7'b0000011 && ex[11:7] != 5'd0 && reads_reg(id, ex[11:7]);
   endfunction

   function automatic bit is_mul(input logic [31:0] ex);
      return ex[6:0] == 7'b0110011 && ex[31:25] == 7'b0000001;
   endfunction

   // {stall_pc, stall_ifid, stall_idex, bubble_idex, flush_ifid, mdu_start, mdu_err, stall_cnt}
   function automatic logic [22:0] expect_now();
      logic [5:0] o;
      if (rst)                                          o = 6'b000000;
      else if (m_pending)                               o = 6'b111000;
      else if (m_drain)                                 o = 6'b000100;
      else if (hz.ex_br_taken)                          o = 6'b000110;
      else if (load_hazard(hz.ex_instr, hz.id_instr))   o = 6'b110100;
      else if (is_mul(hz.ex_instr))                     o = 6'b000001;
      else                                              o = 6'b000000;
      return {o, m_err, 16'(m_cnt)};
   endfunction

   function automatic logic [22:0] observe();
      return {hz.stall_pc, hz.stall_ifid, hz.stall_idex, hz.bubble_idex, hz.flush_ifid,
              hz.mdu_start, hz.mdu_err, hz.stall_cnt};
   endfunction

   task automatic drive(input logic [31:0] ex, input logic [31:0] id, input logic br, input logic done);
      hz.ex_instr    = ex;
      hz.id_instr    = id;
      hz.ex_br_taken = br;
      hz.mdu_done    = done;
   endtask

   // Apply the current inputs to the model, then take the clock edge.
   task automatic advance();
      logic [22:0] e;
      e = expect_now();
      if (rst) begin
         m_pending = 0; m_drain = 0; m_err = 0; m_age = 0; m_cnt = 0;
      end else begin
         if (e[22] && m_cnt < 65535) m_cnt++;
         if (m_pending) begin
            m_age++;
            if (hz.mdu_done) begin
               m_pending = 0; m_drain = 1;
            end else if (m_age == TO) begin
               m_pending = 0; m_drain = 1; m_err = 1;
            end
         end else if (m_drain) begin
            m_drain = 0;
         end else if (!hz.ex_br_taken && is_mul(hz.ex_instr)) begin
            m_pending = 1; m_age = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [4:0]  a, b, d;
      r = $urandom();
      a = 5'($urandom_range(0, 7));
      b = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
         0, 1:    return {r[31:20], a, 3'b010, d, 7'b0000011};
         2:       return {7'b0000001, b, a, 3'b000, d, 7'b0110011};
         3:       return {7'b0000000, b, a, 3'b000, d, 7'b0110011};
         4:       return {r[31:25], b, a, 3'b000, d, 7'b0010011};
         5:       return {r[31:25], b, a, 3'b010, r[11:7], 7'b0100011};
         6:       return {r[31:25], b, a, 3'b000, r[11:7], 7'b1100011};
         default: begin
            case ($urandom_range(0, 2))
               0:       return {r[31:25], b, a, r[14:12], d, 7'b0110111};
               1:       return {r[31:25], b, a, r[14:12], d, 7'b0010111};
               default: return {r[31:25], b, a, r[14:12], d, 7'b1101111};
            endcase
         end
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      drive(LW5, ADD, 1'b0, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (observe() !== expect_now()) begin
         n_bad++; $display("FAIL reset_hold got=%h exp=%h", observe(), expect_now());
      end
      advance();
      rst = 1'b0;
      drive(NOP, NOP, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (observe() !== 23'd0) begin
         n_bad++; $display("FAIL reset_idle got=%h exp=%h", observe(), 23'd0);
      end
      advance();
   endtask

   task automatic test_load_use();
      logic [31:0] ex_t [5] = '{LW5, 32'h0000_2003, 32'h0001_2083, LW5, LW5};
      logic [31:0] id_t [5] = '{ADD, 32'h0000_0033, 32'h0012_8313, 32'h0050_2023, 32'h0000_52B7};
      int c0;
      c0 = m_cnt;
      for (int k = 0; k < 5; k++) begin
         drive(ex_t[k], id_t[k], 1'b0, 1'b0);
         @(negedge clk);
         n_cmp++;
         if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL load_use[%0d] got=%h exp=%h", k, observe(), expect_now());
         end
         advance();
      end
      drive(NOP, NOP, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      // lw x5 feeding add (rs1) and sw (rs2) stall; lw x0, unused rs2 and LUI do not.
      if (hz.stall_cnt !== 16'(c0 + 2)) begin
         n_bad++; $display("FAIL load_use_cnt got=%0d exp=%0d", hz.stall_cnt, c0 + 2);
      end
      advance();
   endtask

   task automatic test_branch_priority();
      int c0;
      c0 = m_cnt;
      drive(LW5, ADD, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if ({hz.stall_pc, hz.bubble_idex, hz.flush_ifid} !== 3'b011) begin
         n_bad++; $display("FAIL branch_over_load got=%b exp=011",
                           {hz.stall_pc, hz.bubble_idex, hz.flush_ifid});
      end
      advance();
      drive(MUL, NOP, 1'b1, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (observe() !== expect_now()) begin
         n_bad++; $display("FAIL branch_over_mul got=%h exp=%h", observe(), expect_now());
      end
      advance();
      drive(NOP, NOP, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (hz.stall_cnt !== 16'(c0) || hz.stall_idex !== 1'b0) begin
         n_bad++; $display("FAIL branch_cnt got=%0d exp=%0d", hz.stall_cnt, c0);
      end
      advance();
   endtask

   task automatic test_mdu_done();
      logic [31:0] ex_t [6] = '{MUL, MUL, MUL, MUL, MUL, NOP};
      logic        br_t [6] = '{0, 1, 0, 0, 0, 0};
      logic        dn_t [6] = '{1, 0, 0, 1, 1, 0};
      int c0, starts, stalls;
      c0 = m_cnt; starts = 0; stalls = 0;
      for (int k = 0; k < 6; k++) begin
         drive(ex_t[k], LW5, br_t[k], dn_t[k]);
         @(negedge clk);
         n_cmp++;
         if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL mdu_done[%0d] got=%h exp=%h", k, observe(), expect_now());
         end
         starts += int'(hz.mdu_start);
         stalls += int'(hz.stall_pc);
         advance();
      end
      n_cmp++;
      if (starts != 1 || stalls != 3 || hz.stall_cnt !== 16'(c0 + 3)) begin
         n_bad++; $display("FAIL mdu_done_totals got=%0d/%0d/%0d exp=1/3/%0d",
                           starts, stalls, hz.stall_cnt, c0 + 3);
      end
   endtask

   task automatic test_mdu_timeout();
      int stalls;
      stalls = 0;
      for (int k = 0; k < 72; k++) begin
         drive((k < 66) ? MUL : NOP, NOP, 1'b0, (k >= 66) ? 1'b1 : 1'b0);
         @(negedge clk);
         n_cmp++;
         if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL mdu_timeout[%0d] got=%h exp=%h", k, observe(), expect_now());
         end
         stalls += int'(hz.stall_pc);
         advance();
      end
      n_cmp++;
      if (stalls != TO || hz.mdu_err !== 1'b1) begin
         n_bad++; $display("FAIL mdu_timeout_totals stalls=%0d err=%b exp=%0d/1",
                           stalls, hz.mdu_err, TO);
      end
   endtask

   task automatic test_saturation();
      drive(LW5, ADD, 1'b0, 1'b0);
      for (int k = 0; k < 65540; k++) advance();
      @(negedge clk);
      n_cmp++;
      if (hz.stall_cnt !== 16'hFFFF || observe() !== expect_now()) begin
         n_bad++; $display("FAIL saturation got=%h exp=%h", hz.stall_cnt, 16'hFFFF);
      end
      advance();
      advance();
      @(negedge clk);
      n_cmp++;
      if (hz.stall_cnt !== 16'hFFFF) begin
         n_bad++; $display("FAIL saturation_hold got=%h exp=%h", hz.stall_cnt, 16'hFFFF);
      end
      advance();
   endtask

   task automatic test_reset_mid_busy();
      drive(MUL, NOP, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) advance();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (observe() !== expect_now() || hz.mdu_start !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy got=%h exp=%h", observe(), expect_now());
      end
      advance();
      rst = 1'b0;
      drive(NOP, NOP, 1'b0, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (observe() !== 23'd0) begin
         n_bad++; $display("FAIL reset_busy_after got=%h exp=%h", observe(), 23'd0);
      end
      advance();
   endtask

   task automatic test_random();
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 149) == 0);
         drive(rand_instr(), rand_instr(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
         @(negedge clk);
         n_cmp++;
         if (observe() !== expect_now()) begin
            n_bad++; $display("FAIL random[%0d] got=%h exp=%h", k, observe(), expect_now());
         end
         advance();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_priority();
      test_mdu_done();
      test_mdu_timeout();
      test_saturation();
      test_reset_mid_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
